// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/S_Box.sv
// AES forward S-box, one byte, combinational lookup.
module S_Box (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 sits in the top byte, so index with the inverted input.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base   = {~byte_i, 3'b000};
  assign byte_o = SBOX[base +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four byte-parallel S-boxes, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    S_Box u_sbox (
      .byte_i (word_i[8*b +: 8]),
      .byte_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, rounds 0..NR.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  output logic [3:0]       rk_round,
  output logic [KEY_W-1:0] rk_out,
  output logic             done
);

  state_e state_q, state_d;

  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       rcon_q, rcon_d;

  logic              last;
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot, sub, temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign last = (cnt_q == 4'(NR));

  assign {w0, w1, w2, w3} = key_q;
  assign rot = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub (
    .word_i (rot),
    .word_o (sub)
  );

  assign temp = sub ^ {rcon_q, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On the final round the freshly computed key is dropped so rk_out holds.
  always_comb begin
    key_d  = key_q;
    cnt_d  = cnt_q;
    rcon_d = rcon_q;
    unique case (1'b1)
      (state_q == IDLE) && start: begin
        key_d  = key_in;
        cnt_d  = '0;
        rcon_d = RCON_INIT;
      end
      (state_q == EXPAND) && !last: begin
        key_d  = {n0, n1, n2, n3};
        cnt_d  = cnt_q + 4'd1;
        rcon_d = xtime(rcon_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q == EXPAND);
    rk_valid = (state_q == EXPAND);
    done     = (state_q == EXPAND) && last;
    rk_round = cnt_q;
    rk_out   = key_q;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised bench for aes_key_expand against a GF(2^8) key-schedule model.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = 8'h63 ^ inv;
    for (int n = 1; n <= 4; n++)
      s ^= 8'((inv << n) | (inv >> (8 - n)));
    return s;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic burst(input logic [127:0] key, input bit scramble);
    int nvalid = 0;
    model_expand(key);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (scramble) key_in = {$urandom, $urandom, $urandom, $urandom};
      if (rk_valid) nvalid++;
      chk($sformatf("valid%0d", i), 128'(rk_valid), 128'(1));
      chk($sformatf("busy%0d", i), 128'(busy), 128'(1));
      chk($sformatf("round%0d", i), 128'(rk_round), 128'(i));
      chk($sformatf("rk%0d", i), rk_out, exp_rk[i]);
      chk($sformatf("done%0d", i), 128'(done), 128'(i == 10));
      got_rk[i] = rk_out;
    end
    chk("nvalid", 128'(nvalid), 128'(11));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    logic [127:0] ka;
    bit           exp_v;
    int           exp_r;

    rst    = 1'b0;
    start  = 1'b0;
    key_in = '0;
    #3 rst = 1'b1;
    #4;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_rk", rk_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    burst(FIPS, 1'b0);
    chk("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    idle_check("fips_end");

    burst(128'h0, 1'b0);
    chk("zero_r1", got_rk[1], 128'h62636363626363636263636362636363);
    chk("zero_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_check("zero_end");

    // Back-to-back: random key A with key_in churning, then FIPS as B.
    ka = {$urandom, $urandom, $urandom, $urandom};
    burst(ka, 1'b1);
    burst(FIPS, 1'b0);
    chk("b2b_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    idle_check("b2b_end");

    // start held for 20 edges: bursts accepted at T and T+12 only.
    model_expand(FIPS);
    @(negedge clk);
    key_in = FIPS;
    start  = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      exp_v = (i <= 11) || (i >= 13 && i <= 23);
      exp_r = (i <= 11) ? i - 1 : i - 13;
      chk($sformatf("hold_valid%0d", i), 128'(rk_valid), 128'(exp_v));
      if (exp_v) begin
        chk($sformatf("hold_round%0d", i), 128'(rk_round), 128'(exp_r));
        chk($sformatf("hold_rk%0d", i), rk_out, exp_rk[exp_r]);
        chk($sformatf("hold_done%0d", i), 128'(done), 128'(exp_r == 10));
      end
      if (i == 20) start = 1'b0;
    end

    // Asynchronous reset in the middle of round 5.
    @(negedge clk);
    key_in = FIPS;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_round", 128'(rk_round), 128'(5));
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_valid", 128'(rk_valid), 128'(0));
    chk("mid_done", 128'(done), 128'(0));
    chk("mid_rk", rk_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    burst(FIPS, 1'b0);
    idle_check("post_rst");

    for (int k = 0; k < 4; k++)
      burst({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle_check("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
